// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, ALU function codes,
// controller state encoding and the WAIT-state timeout limit.
package alu_ctrl_pkg;

  // Instruction opcodes (instr[15:12]); 0x9-0xE are illegal
  localparam logic [3:0] OP_MOVB = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_CMP  = 4'h7;
  localparam logic [3:0] OP_BZ   = 4'h8;
  localparam logic [3:0] OP_NOP  = 4'hF;

  // Function codes presented on alu_func
  localparam logic [2:0] FN_MOVB = 3'b000;
  localparam logic [2:0] FN_ADD  = 3'b001;
  localparam logic [2:0] FN_SUB  = 3'b010;
  localparam logic [2:0] FN_AND  = 3'b011;
  localparam logic [2:0] FN_OR   = 3'b100;
  localparam logic [2:0] FN_SHL  = 3'b101;
  localparam logic [2:0] FN_SHR  = 3'b110;

  // Cycles spent in WAIT without alu_done before giving up
  localparam logic [3:0] TIMEOUT_LIMIT = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WAIT,
    S_WB
  } state_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Opcode decoder for the ALU sequencer: purely combinational classification
// of the registered opcode.
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [2:0] alu_func,
  output logic       writes_rd,
  output logic       sets_zero,
  output logic       is_branch,
  output logic       is_nop,
  output logic       is_illegal
);

  // Map opcode to ALU function and control attributes
  always_comb begin
    alu_func   = FN_MOVB;
    writes_rd  = 1'b0;
    sets_zero  = 1'b0;
    is_branch  = 1'b0;
    is_nop     = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_MOVB: begin alu_func = FN_MOVB; writes_rd = 1'b1; end
      OP_ADD:  begin alu_func = FN_ADD;  writes_rd = 1'b1; end
      OP_SUB:  begin alu_func = FN_SUB;  writes_rd = 1'b1; sets_zero = 1'b1; end
      OP_AND:  begin alu_func = FN_AND;  writes_rd = 1'b1; end
      OP_OR:   begin alu_func = FN_OR;   writes_rd = 1'b1; end
      OP_SHL:  begin alu_func = FN_SHL;  writes_rd = 1'b1; end
      OP_SHR:  begin alu_func = FN_SHR;  writes_rd = 1'b1; end
      OP_CMP:  begin alu_func = FN_SUB;  sets_zero = 1'b1; end
      OP_BZ:   is_branch  = 1'b1;
      OP_NOP:  is_nop     = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// ALU sequencer: fetches one instruction, reads the register file, drives an
// external ALU through an en/done handshake and writes the result back.
// Optional feature: define ALU_CTRL_TIMEOUT_EN to abandon an ALU operation
// after 15 cycles in WAIT without alu_done (timeout pulse, no writeback).
module alu_ctrl
  import alu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [3:0]  rf_ra,
  output logic [3:0]  rf_rb,
  input  logic [15:0] rf_a_data,
  input  logic [15:0] rf_b_data,
  output logic        alu_en,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_func,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        wb_en,
  output logic [3:0]  wb_addr,
  output logic [15:0] wb_data,
  output logic        br_valid,
  output logic [11:0] br_target,
  output logic        zero,
  output logic        illegal,
  output logic        timeout
);

  state_t      state_q, state_d;
  logic [3:0]  op_q;
  logic [3:0]  rd_q;
  logic [2:0]  dec_func;
  logic        dec_writes_rd;
  logic        dec_sets_zero;
  logic        dec_is_branch;
  logic        dec_is_nop;
  logic        dec_is_illegal;
  logic        wait_expired;

  alu_ctrl_dec u_dec (
    .opcode     (op_q),
    .alu_func   (dec_func),
    .writes_rd  (dec_writes_rd),
    .sets_zero  (dec_sets_zero),
    .is_branch  (dec_is_branch),
    .is_nop     (dec_is_nop),
    .is_illegal (dec_is_illegal)
  );

`ifdef ALU_CTRL_TIMEOUT_EN
  logic [3:0] wait_cnt;
  logic       timeout_q;

  assign wait_expired = (state_q == S_WAIT) && !alu_done &&
                        (wait_cnt == TIMEOUT_LIMIT - 4'd1);
  assign timeout      = timeout_q;

  // Count WAIT cycles without alu_done; pulse timeout on expiry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wait_expired;
      if (state_q != S_WAIT)
        wait_cnt <= '0;
      else if (!alu_done)
        wait_cnt <= wait_cnt + 4'd1;
    end
  end
`else
  assign wait_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  // State register, instruction fields and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      rf_ra     <= '0;
      rf_rb     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_func  <= FN_MOVB;
      wb_addr   <= '0;
      wb_data   <= '0;
      br_valid  <= 1'b0;
      br_target <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state_q  <= state_d;
      br_valid <= 1'b0;
      illegal  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            op_q  <= instr[15:12];
            rd_q  <= instr[11:8];
            rf_ra <= instr[7:4];
            rf_rb <= instr[3:0];
          end
        end
        S_READ: begin
          // Branch target is the low 12 instruction bits, kept split across
          // rd/ra/rb so no separate copy of the instruction is needed
          if (dec_is_branch) begin
            if (zero) begin
              br_valid  <= 1'b1;
              br_target <= {rd_q, rf_ra, rf_rb};
            end
          end else if (dec_is_illegal) begin
            illegal <= 1'b1;
          end else if (!dec_is_nop) begin
            alu_a    <= rf_a_data;
            alu_b    <= rf_b_data;
            alu_func <= dec_func;
          end
        end
        S_WAIT: begin
          if (alu_done) begin
            if (dec_sets_zero)
              zero <= (alu_result == 16'h0000);
            if (dec_writes_rd) begin
              wb_addr <= rd_q;
              wb_data <= alu_result;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic and state-decoded strobes
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    alu_en      = 1'b0;
    wb_en       = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = !rst;
        if (instr_valid)
          state_d = S_READ;
      end
      S_READ: begin
        if (dec_is_branch || dec_is_illegal || dec_is_nop)
          state_d = S_IDLE;
        else
          state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_en  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (alu_done)
          state_d = dec_writes_rd ? S_WB : S_IDLE;
        else if (wait_expired)
          state_d = S_IDLE;
      end
      S_WB: begin
        wb_en   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed scoreboard bench for alu_ctrl with a 1-cycle ALU model and a
// combinational register-file model.
module tb_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  rf_ra, rf_rb;
  logic [15:0] rf_a_data, rf_b_data;
  logic        alu_en;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_func;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        br_valid;
  logic [11:0] br_target;
  logic        zero, illegal, timeout;

  int errors = 0;
  int checks = 0;

  typedef enum logic [1:0] {EV_WB, EV_BR, EV_ILL, EV_TO} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [3:0]  addr;
    logic [15:0] data;
  } ev_t;
  ev_t sb[$];
  ev_t mon_e;

  logic [15:0] regs [16];
  logic        model_on;
  logic        model_done;
  logic        manual_done;

  alu_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rf_ra       (rf_ra),
    .rf_rb       (rf_rb),
    .rf_a_data   (rf_a_data),
    .rf_b_data   (rf_b_data),
    .alu_en      (alu_en),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_func    (alu_func),
    .alu_done    (alu_done),
    .alu_result  (alu_result),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .zero        (zero),
    .illegal     (illegal),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  assign rf_a_data = regs[rf_ra];
  assign rf_b_data = regs[rf_rb];

  // External ALU model: done one cycle after en
  always @(posedge clk or posedge rst)
    if (rst) model_done <= 1'b0;
    else     model_done <= alu_en && model_on;

  assign alu_done = model_done | manual_done;

  always_comb begin
    alu_result = 16'h0000;
    case (alu_func)
      3'b000: alu_result = alu_b;
      3'b001: alu_result = alu_a + alu_b;
      3'b010: alu_result = alu_a - alu_b;
      3'b011: alu_result = alu_a & alu_b;
      3'b100: alu_result = alu_a | alu_b;
      3'b101: alu_result = alu_a << alu_b[3:0];
      3'b110: alu_result = alu_a >> alu_b[3:0];
      default: alu_result = 16'h0000;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every strobe pops one expected event
  always @(negedge clk) begin
    if (!rst && (wb_en || br_valid || illegal || timeout)) begin
      if (sb.size() == 0) begin
        check("unexpected_event", {28'h0, wb_en, br_valid, illegal, timeout}, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        case (mon_e.kind)
          EV_WB: begin
            check("wb_strobes", {wb_en, br_valid, illegal, timeout}, 4'b1000);
            check("wb_addr", wb_addr, mon_e.addr);
            check("wb_data", wb_data, mon_e.data);
          end
          EV_BR: begin
            check("br_strobes", {wb_en, br_valid, illegal, timeout}, 4'b0100);
            check("br_target", br_target, mon_e.data[11:0]);
          end
          EV_ILL: check("ill_strobes", {wb_en, br_valid, illegal, timeout}, 4'b0010);
          EV_TO:  check("to_strobes",  {wb_en, br_valid, illegal, timeout}, 4'b0001);
          default: ;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] rd,
                       input logic [3:0] ra, input logic [3:0] rb);
    int n = 0;
    while (!instr_ready && n < 50) begin
      tick();
      n++;
    end
    check("ready_before_issue", instr_ready, 1'b1);
    instr_valid = 1'b1;
    instr       = {op, rd, ra, rb};
    tick();
    instr_valid = 1'b0;
    instr       = 16'h0000;
  endtask

  task automatic run_alu(input string tag, input logic [3:0] op, input logic [3:0] rd,
                         input logic [3:0] ra, input logic [3:0] rb,
                         input logic [2:0] fn, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] d, input logic wr, input logic z);
    if (wr) sb.push_back('{EV_WB, rd, d});
    issue(op, rd, ra, rb);
    check({tag, "_ready_read"}, {instr_ready, alu_en}, 2'b00);
    tick();
    check({tag, "_alu_en"}, alu_en, 1'b1);
    check({tag, "_alu_func"}, alu_func, fn);
    check({tag, "_alu_ab"}, {alu_a, alu_b}, {a, b});
    tick();
    check({tag, "_alu_en_off"}, alu_en, 1'b0);
    tick();
    if (wr) begin
      check({tag, "_wb_en"}, wb_en, 1'b1);
      tick();
    end else begin
      check({tag, "_no_wb"}, wb_en, 1'b0);
    end
    check({tag, "_ready_after"}, instr_ready, 1'b1);
    check({tag, "_zero"}, zero, z);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    model_on    = 1'b1;
    manual_done = 1'b0;
    for (int i = 0; i < 16; i++) regs[i] = 16'h0000;
    regs[1]  = 16'h0005; regs[2] = 16'h0007;
    regs[4]  = 16'h1234; regs[5] = 16'h1234;
    regs[6]  = 16'h0001; regs[7] = 16'h0002;
    regs[8]  = 16'h00F0; regs[9] = 16'h0004;
    regs[10] = 16'h0F0F;

    // Reset state
    tick();
    check("rst_ready", instr_ready, 1'b0);
    check("rst_strobes", {alu_en, wb_en, br_valid, illegal, timeout, zero}, 6'b0);
    check("rst_data", {alu_a, alu_b, wb_data}, 48'h0);
    check("rst_addr", {alu_func, rf_ra, rf_rb, wb_addr, br_target}, 27'h0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", instr_ready, 1'b1);

    run_alu("add",  4'h1, 4'h3, 4'h1, 4'h2, 3'b001, 16'h0005, 16'h0007, 16'h000C, 1'b1, 1'b0);
    run_alu("cmp",  4'h7, 4'h0, 4'h4, 4'h5, 3'b010, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1);

    // Taken branch
    sb.push_back('{EV_BR, 4'h0, 16'h00A5});
    issue(4'h8, 4'h0, 4'hA, 4'h5);
    tick();
    check("bz_taken_valid", br_valid, 1'b1);
    check("bz_taken_target", br_target, 12'h0A5);
    check("bz_ready", instr_ready, 1'b1);
    tick();
    check("bz_pulse_end", br_valid, 1'b0);
    check("alu_a_held", alu_a, 16'h1234);

    run_alu("sub",  4'h2, 4'h9, 4'h6, 4'h7, 3'b010, 16'h0001, 16'h0002, 16'hFFFF, 1'b1, 1'b0);

    // Branch not taken after nonzero SUB
    issue(4'h8, 4'h1, 4'h2, 4'h3);
    tick();
    check("bz_not_taken", br_valid, 1'b0);
    tick();

    run_alu("and",  4'h3, 4'hB, 4'h8, 4'hA, 3'b011, 16'h00F0, 16'h0F0F, 16'h0000, 1'b1, 1'b0);
    run_alu("movb", 4'h0, 4'h2, 4'h0, 4'h8, 3'b000, 16'h0000, 16'h00F0, 16'h00F0, 1'b1, 1'b0);
    run_alu("shl",  4'h5, 4'h7, 4'h8, 4'h9, 3'b101, 16'h00F0, 16'h0004, 16'h0F00, 1'b1, 1'b0);
    run_alu("shr",  4'h6, 4'hE, 4'h8, 4'h9, 3'b110, 16'h00F0, 16'h0004, 16'h000F, 1'b1, 1'b0);

    // Illegal opcode
    sb.push_back('{EV_ILL, 4'h0, 16'h0000});
    issue(4'hB, 4'h1, 4'h1, 4'h2);
    check("ill_read_alu_en", alu_en, 1'b0);
    tick();
    check("ill_pulse", illegal, 1'b1);
    check("ill_no_alu_en", alu_en, 1'b0);
    check("ill_ready", instr_ready, 1'b1);
    tick();
    check("ill_pulse_end", illegal, 1'b0);

    // NOP with a stray alu_done held outside WAIT
    manual_done = 1'b1;
    issue(4'hF, 4'h1, 4'h1, 4'h2);
    tick();
    check("nop_ready", instr_ready, 1'b1);
    tick();
    manual_done = 1'b0;
    check("stray_done_no_wb", wb_en, 1'b0);

    run_alu("cmp2", 4'h7, 4'h0, 4'h4, 4'h5, 3'b010, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1);
    run_alu("add2", 4'h1, 4'h6, 4'h1, 4'h2, 3'b001, 16'h0005, 16'h0007, 16'h000C, 1'b1, 1'b1);

    // Reset during WAIT of an ADD: no writeback afterwards
    issue(4'h1, 4'h5, 4'h1, 4'h2);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_ready", instr_ready, 1'b0);
    check("midrst_strobes", {alu_en, wb_en, br_valid, illegal, timeout, zero}, 6'b0);
    check("midrst_data", {alu_a, alu_b, wb_data}, 48'h0);
    check("midrst_addr", {alu_func, rf_ra, rf_rb, wb_addr, br_target}, 27'h0);
    tick();
    rst = 1'b0;
    tick();
    check("midrst_ready_after", instr_ready, 1'b1);
    check("midrst_no_wb", wb_en, 1'b0);
    tick();
    tick();

    // ALU never answers
    model_on = 1'b0;
    issue(4'h1, 4'h4, 4'h1, 4'h2);
    tick();
    check("to_alu_en", alu_en, 1'b1);
    for (int i = 0; i < 15; i++) tick();
    check("to_pre_pulse", {timeout, instr_ready}, 2'b00);
`ifdef ALU_CTRL_TIMEOUT_EN
    sb.push_back('{EV_TO, 4'h0, 16'h0000});
    tick();
    check("to_pulse", timeout, 1'b1);
    check("to_ready", instr_ready, 1'b1);
    check("to_no_wb", wb_en, 1'b0);
    tick();
    check("to_pulse_end", timeout, 1'b0);
`else
    for (int i = 0; i < 6; i++) tick();
    check("no_to_still_waiting", {timeout, instr_ready}, 2'b00);
    sb.push_back('{EV_WB, 4'h4, 16'h000C});
    manual_done = 1'b1;
    tick();
    manual_done = 1'b0;
    check("late_done_wb", wb_en, 1'b1);
    tick();
    check("late_done_ready", instr_ready, 1'b1);
`endif
    model_on = 1'b1;
    run_alu("or",   4'h4, 4'h1, 4'h8, 4'hA, 3'b100, 16'h00F0, 16'h0F0F, 16'h0FFF, 1'b1, 1'b0);

    tick();
    tick();
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock, rising edge; rst  in  1  asynchronous reset, active-high.
REQ-002 SHALL have instruction port: instr_valid  in  1; instr_ready  out  1; instr  in  16  [15:12] opcode, [11:8] rd, [7:4] ra, [3:0] rb, [11:0] branch target.
REQ-003 SHALL have register-file read port: rf_ra  out  4; rf_rb  out  4; rf_a_data  in  16; rf_b_data  in  16 (combinational read).
REQ-004 SHALL have ALU-drive port: alu_en  out  1 (to ALU en_in); alu_a  out  16; alu_b  out  16; alu_func  out  3; alu_done  in  1 (from ALU en_out); alu_result  in  16.
REQ-005 SHALL have writeback port: wb_en  out  1; wb_addr  out  4; wb_data  out  16.
REQ-006 SHALL have status: br_valid  out  1; br_target  out  12; zero  out  1; illegal  out  1; timeout  out  1.

Function
REQ-007 SHALL map opcodes: 0x0 MOVB->000, 0x1 ADD->001, 0x2 SUB->010, 0x3 AND->011, 0x4 OR->100, 0x5 SHL->101, 0x6 SHR->110, 0x7 CMP->010 no writeback, 0x8 BZ, 0xF NOP; 0x9-0xE illegal.
REQ-008 SHALL use states IDLE, READ, EXEC, WAIT, WB.
REQ-009 SHALL assert instr_ready only in IDLE; accept on instr_valid&&instr_ready, register instr, go READ.
REQ-010 READ: rf_ra=ra, rf_rb=rb; sample rf_a_data/rf_b_data into operand regs at end of cycle; ALU opcodes go EXEC.
REQ-011 READ with BZ: br_valid one-cycle pulse next cycle with br_target=instr[11:0] iff zero==1; return IDLE; no ALU access.
REQ-012 READ with NOP: return IDLE; with illegal opcode: illegal one-cycle pulse, return IDLE.
REQ-013 EXEC: alu_en=1 for exactly one cycle with alu_a/alu_b/alu_func held stable; go WAIT.
REQ-014 alu_a/alu_b/alu_func SHALL hold value from EXEC until next EXEC; alu_en=0 in all other states.
REQ-015 WAIT: on alu_done=1 capture alu_result; CMP/SUB set zero=(alu_result==16'h0); other opcodes leave zero unchanged; CMP goes IDLE, others go WB.
REQ-016 WB: wb_en=1 one cycle, wb_addr=rd, wb_data=captured result; go IDLE.
REQ-017 Nominal ALU latency: accept T, READ T+1, EXEC T+2, alu_done T+3, wb_en T+4, instr_ready T+5.
REQ-018 alu_done outside WAIT SHALL be ignored.
REQ-019 Arithmetic width SHALL be 16 bits; carry/overflow not tracked.

Reset
REQ-020 rst=1 SHALL force IDLE immediately; instr_ready=0 while rst=1, 1 the first cycle after release.
REQ-021 Reset values: alu_en, wb_en, br_valid, illegal, timeout, zero=0; alu_a, alu_b, wb_data=16'h0; alu_func=3'b000; rf_ra, rf_rb, wb_addr=4'h0; br_target=12'h0.
REQ-022 Reset mid-instruction SHALL discard it; no wb_en or br_valid after release.

Configuration
REQ-023 Macro ALU_CTRL_TIMEOUT_EN defined: 4-bit counter in WAIT; alu_done absent 15 cycles -> timeout one-cycle pulse, no writeback, zero unchanged, return IDLE.
REQ-024 Macro undefined: WAIT indefinitely; timeout tied 0; no counter.

Structure
REQ-025 Package alu_ctrl_pkg SHALL hold opcode constants, 3-bit alu_func codes, state enum typedef, timeout limit constant (15).
REQ-026 Combinational sub-module alu_ctrl_dec: opcode -> alu_func, writes_rd, sets_zero, is_branch, is_nop, is_illegal.

Verification
REQ-027 Reset mid-WAIT of ADD -> IDLE, no wb_en, all outputs at reset values, instr_ready=1 after release.
REQ-028 ADD rd=3, rf_a=16'h0005, rf_b=16'h0007, ALU model 1-cycle -> alu_en at T+2 with func 001, wb_en T+4, wb_addr=3, wb_data=16'h000C.
REQ-029 CMP with 16'h1234,16'h1234 -> zero=1, no wb_en; then BZ target 12'h0A5 -> br_valid one cycle, br_target=12'h0A5.
REQ-030 SUB 16'h0001-16'h0002 -> wb_data=16'hFFFF, zero=0; following BZ -> no br_valid.
REQ-031 Opcode 0xB -> illegal pulse one cycle, no alu_en, instr_ready back at T+2.
REQ-032 ALU_CTRL_TIMEOUT_EN defined, alu_done held 0 -> timeout pulse 15 cycles into WAIT, no wb_en, next instruction accepted normally.
